// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types and constants for the serializer and the 111 detector side
package seq_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int SEQ_WIDTH = 8;

endpackage

// File: rtl/serial_stream_serializer_if.sv
// rtl/serial_stream_serializer_if.sv - word handshake in, serial bit stream out
interface serial_stream_serializer_if #(
    parameter int WIDTH = seq_pkg::SEQ_WIDTH
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             x;
    logic             x_valid;
    logic             busy;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  x,
        input  x_valid,
        input  busy
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output x,
        output x_valid,
        output busy
    );
endinterface

// File: rtl/serial_stream_serializer.sv
// rtl/serial_stream_serializer.sv - parallel word to registered serial bit stream, gapless back-to-back
module serial_stream_serializer
    import seq_pkg::*;
#(
    parameter int WIDTH     = SEQ_WIDTH,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst,
    serial_stream_serializer_if.slave   s
);
    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH);
    localparam logic [CW-1:0]  ONE  = CW'(1);

    state_t           state, state_nx;
    logic [WIDTH-1:0] sreg, sreg_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic             x_q, x_nx;
    logic             xv_q, xv_nx;

    logic             last;
    logic             ready;
    logic             accept;
    logic             load_bit;
    logic [WIDTH-1:0] load_rest;
    logic             shift_bit;
    logic [WIDTH-1:0] shift_rest;

    // The first bit goes straight to x on load, so sreg holds only the bits still to come.
    assign load_bit   = MSB_FIRST ? s.in_data[WIDTH-1] : s.in_data[0];
    assign load_rest  = MSB_FIRST ? (s.in_data << 1) : (s.in_data >> 1);
    assign shift_bit  = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
    assign shift_rest = MSB_FIRST ? (sreg << 1) : (sreg >> 1);

    assign last   = (state == SHIFT) && (cnt == LAST);
    assign ready  = (state == IDLE) || last;
    assign accept = ready && s.in_valid;

    always_comb begin
        state_nx = state;
        sreg_nx  = sreg;
        cnt_nx   = cnt;
        x_nx     = x_q;
        xv_nx    = xv_q;
        if (accept) begin
            state_nx = SHIFT;
            sreg_nx  = load_rest;
            cnt_nx   = ONE;
            x_nx     = load_bit;
            xv_nx    = 1'b1;
        end else if (last) begin
            state_nx = IDLE;
            sreg_nx  = '0;
            cnt_nx   = '0;
            x_nx     = IDLE_BIT;
            xv_nx    = 1'b0;
        end else if (state == SHIFT) begin
            sreg_nx  = shift_rest;
            cnt_nx   = cnt + ONE;
            x_nx     = shift_bit;
            xv_nx    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
            x_q   <= IDLE_BIT;
            xv_q  <= 1'b0;
        end else begin
            state <= state_nx;
            sreg  <= sreg_nx;
            cnt   <= cnt_nx;
            x_q   <= x_nx;
            xv_q  <= xv_nx;
        end
    end

    assign s.in_ready = ready;
    assign s.x        = x_q;
    assign s.x_valid  = xv_q;
    assign s.busy     = (state == SHIFT);

endmodule

// File: tb/tb_serial_stream_serializer.sv
// tb/tb_serial_stream_serializer.sv - directed and random checks of two serializer configurations
module tb_serial_stream_serializer;
    import seq_pkg::*;

    localparam int W      = SEQ_WIDTH;
    localparam bit IDLE_M = 1'b0;
    localparam bit IDLE_L = 1'b1;

    logic         clk      = 1'b0;
    logic         rst      = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data  = '0;

    int vec  = 0;
    int errs = 0;

    serial_stream_serializer_if #(.WIDTH(W)) ifm ();
    serial_stream_serializer_if #(.WIDTH(W)) ifl ();

    assign ifm.in_data  = in_data;
    assign ifm.in_valid = in_valid;
    assign ifl.in_data  = in_data;
    assign ifl.in_valid = in_valid;

    serial_stream_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(IDLE_M)) dut_m (
        .clk (clk),
        .rst (rst),
        .s   (ifm.slave)
    );

    serial_stream_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(IDLE_L)) dut_l (
        .clk (clk),
        .rst (rst),
        .s   (ifl.slave)
    );

    always #5 clk = ~clk;

    // Reference: each DUT holds a word as its bits listed in transmit order plus the index on x.
    logic [W-1:0] mseq [2];
    int           mpos [2];
    bit           mv   [2];
    logic [15:0]  cap_m = '0;
    logic [15:0]  cap_l = '0;

    function automatic logic [W-1:0] order(input logic [W-1:0] w, input bit lsb_first);
        logic [W-1:0] r;
        for (int k = 0; k < W; k++) r[k] = lsb_first ? w[k] : w[W-1-k];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mv[d]   = 1'b0;
            mpos[d] = 0;
            mseq[d] = '0;
        end
    endtask

    task automatic model_edge();
        bit rdy;
        for (int d = 0; d < 2; d++) begin
            rdy = !mv[d] || (mpos[d] == W - 1);
            if (in_valid && rdy) begin
                mseq[d] = order(in_data, d == 1);
                mpos[d] = 0;
                mv[d]   = 1'b1;
            end else if (mv[d] && mpos[d] < W - 1) begin
                mpos[d]++;
            end else begin
                mv[d] = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        logic ex, ev, er;
        for (int d = 0; d < 2; d++) begin
            ev = mv[d];
            ex = mv[d] ? mseq[d][mpos[d]] : (d == 0 ? IDLE_M : IDLE_L);
            er = !mv[d] || (mpos[d] == W - 1);
            if (d == 0) begin
                chk("m.x",        32'(ifm.x),        32'(ex));
                chk("m.x_valid",  32'(ifm.x_valid),  32'(ev));
                chk("m.in_ready", 32'(ifm.in_ready), 32'(er));
                chk("m.busy",     32'(ifm.busy),     32'(ev));
            end else begin
                chk("l.x",        32'(ifl.x),        32'(ex));
                chk("l.x_valid",  32'(ifl.x_valid),  32'(ev));
                chk("l.in_ready", 32'(ifl.in_ready), 32'(er));
                chk("l.busy",     32'(ifl.busy),     32'(ev));
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_edge();
        #1;
        cap_m = {cap_m[14:0], ifm.x};
        cap_l = {cap_l[14:0], ifl.x};
        check_all();
    endtask

    task automatic async_reset();
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
    endtask

    initial begin
        model_reset();

        // Reset held two cycles, then idle with no traffic.
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b1;
        repeat (5) step();

        // Single word, MSB first.
        in_data = 8'hE0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (7) step();
        chk("t2_stream", 32'(cap_m[7:0]), 32'h0000_00E0);
        step();

        // Back-to-back words with a 1-run across the boundary.
        in_data = 8'h03; in_valid = 1'b1;
        step();
        in_data = 8'hC0;
        repeat (8) step();
        in_valid = 1'b0;
        repeat (7) step();
        chk("t3_stream", 32'(cap_m), 32'h0000_03C0);
        step();

        // LSB-first instance.
        in_data = 8'h07; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (7) step();
        chk("t4_stream", 32'(cap_l[7:0]), 32'h0000_00E0);
        step();

        // Asynchronous reset while bit 4 is on the line.
        in_data = 8'hFF; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        async_reset();
        chk("t5_x",       32'(ifm.x),       32'h0);
        chk("t5_x_valid", 32'(ifm.x_valid), 32'h0);
        repeat (2) step();
        rst = 1'b1;
        repeat (4) step();

        // in_data changes after acceptance are ignored.
        in_data = 8'hAA; in_valid = 1'b1;
        step();
        in_valid = 1'b0; in_data = 8'h55;
        repeat (7) step();
        chk("t6_stream_m", 32'(cap_m[7:0]), 32'h0000_00AA);
        chk("t6_stream_l", 32'(cap_l[7:0]), 32'h0000_0055);
        step();

        // Random traffic with data churn and one mid-stream reset.
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = W'($urandom);
            if (i == 200) begin
                async_reset();
                step();
                rst = 1'b1;
            end
            step();
        end

        in_valid = 1'b0;
        repeat (W + 2) step();

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
